// File: rtl/dmem_dma_pkg.sv
// Shared definitions for the data-memory DMA engine: default widths,
// controller state encodings and operation mode codes.
package dmem_dma_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_dma.sv
// Data-memory DMA engine that sits between the CPU memory stage and a
// single-port data memory. It copies or fills a block of words one word
// at a time, stalling the CPU while it owns the memory port, and hands
// the port straight back to the CPU whenever it is idle.
module dmem_dma #(
    parameter int ADDR_W = dmem_dma_pkg::ADDR_W,
    parameter int DATA_W = dmem_dma_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              stall,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);
    import dmem_dma_pkg::*;

    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_word;
    logic              r_mode;
    logic [ADDR_W-1:0] w_idxNext;
    logic              w_lastWord;
    logic              w_accept;

    // A request with a non-zero count is the only thing that loads the
    // operand registers; the last word is reached when i+1 equals len.
    assign w_idxNext  = r_idx + IDX_ONE;
    assign w_lastWord = (w_idxNext == r_len);
    assign w_accept   = (r_state == ST_IDLE) && start && (len != '0);

    // Read data always flows back to the CPU, whoever is addressing memory.
    assign cpu_q = mem_q;
    assign stall = busy;

    // Controller state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand latch, word buffer and index; operands are frozen at acceptance
    // so later changes on the request inputs cannot disturb a running transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_fill <= '0;
            r_word <= '0;
            r_mode <= MODE_COPY;
        end else begin
            if (w_accept) begin
                r_src  <= src;
                r_dst  <= dst;
                r_len  <= len;
                r_fill <= fill_val;
                r_mode <= mode;
                r_idx  <= '0;
            end
            if (r_state == ST_READ) begin
                r_word <= mem_q;
            end
            if ((r_state == ST_WRITE) || (r_state == ST_FILL)) begin
                r_idx <= w_idxNext;
            end
        end
    end

    // Next-state selection; start is only looked at in IDLE.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_nextState = ST_DONE;
                    end else if (mode == MODE_FILL) begin
                        w_nextState = ST_FILL;
                    end else begin
                        w_nextState = ST_READ;
                    end
                end
            end
            ST_READ:  w_nextState = ST_WRITE;
            ST_WRITE: w_nextState = w_lastWord ? ST_DONE : ST_READ;
            ST_FILL:  w_nextState = w_lastWord ? ST_DONE : ST_FILL;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Status outputs and memory-port mux: the CPU owns the port in IDLE and
    // DONE, the engine owns it otherwise, and reset blocks every write.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_addr = cpu_addr;
        mem_we   = cpu_we;
        mem_data = cpu_data;
        unique case (r_state)
            ST_READ: begin
                busy     = 1'b1;
                mem_addr = r_src + r_idx;
                mem_we   = 1'b0;
                mem_data = r_word;
            end
            ST_WRITE, ST_FILL: begin
                busy     = 1'b1;
                mem_addr = r_dst + r_idx;
                mem_we   = 1'b1;
                mem_data = (r_mode == MODE_FILL) ? r_fill : r_word;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        if (reset) begin
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for the data-memory DMA engine, paired with a simple
// asynchronous-read data memory and a word-level reference memory image.
module tb_dmem_dma;
    import dmem_dma_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [7:0]  len;
    logic [15:0] fill_val;
    logic        busy;
    logic        done;
    logic        stall;
    logic [7:0]  cpu_addr;
    logic        cpu_we;
    logic [15:0] cpu_data;
    logic [15:0] cpu_q;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_data;
    logic [15:0] mem_q;

    logic [15:0] mem    [256];
    logic [15:0] refMem [256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        m;
        logic [7:0]  s;
        logic [7:0]  d;
        logic [7:0]  l;
        logic [15:0] f;
        int          expBusy;
    } vec_t;

    vec_t vecs [6];

    dmem_dma dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_data (cpu_data),
        .cpu_q    (cpu_q),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_data (mem_data),
        .mem_q    (mem_q)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Data memory: combinational read, write on the rising edge.
    assign mem_q = mem[mem_addr];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkMemory(input string name);
        int nBad = 0;
        int firstBad = -1;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== refMem[a]) begin
                nBad++;
                if (firstBad < 0) firstBad = a;
            end
        end
        if (nBad != 0)
            $display("[TB] %s first differing address 0x%0h", name, firstBad);
        checkOutput({name, "_memDiffs"}, nBad, 0);
    endtask

    // Reference copy: ascending word-by-word, so overlap replicates words.
    function automatic void refCopy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        for (int k = 0; k < int'(l); k++)
            refMem[(int'(d) + k) % 256] = refMem[(int'(s) + k) % 256];
    endfunction

    function automatic void refFill(input logic [7:0] d, input logic [7:0] l, input logic [15:0] f);
        for (int k = 0; k < int'(l); k++)
            refMem[(int'(d) + k) % 256] = f;
    endfunction

    task automatic cpuWrite(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        cpu_addr = a;
        cpu_data = d;
        cpu_we   = 1'b1;
        @(posedge clock);
        #1 cpu_we = 1'b0;
        refMem[a] = d;
    endtask

    // Issue one request, scramble the request inputs after acceptance, and
    // check latency, stall tracking, pulse width and the resulting memory.
    task automatic applyStimulus(input logic m, input logic [7:0] s, input logic [7:0] d,
                                 input logic [7:0] l, input logic [15:0] f,
                                 input int expBusy, input string name);
        int busyCnt  = 0;
        int stallBad = 0;
        int doneSeen = 0;
        int cycles   = 0;
        @(negedge clock);
        mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        mode     = 1'($urandom);
        src      = 8'($urandom);
        dst      = 8'($urandom);
        len      = 8'($urandom);
        fill_val = 16'($urandom);
        while (doneSeen == 0 && cycles < 1000) begin
            @(negedge clock);
            cycles++;
            if (stall !== busy) stallBad++;
            if (done) doneSeen = 1;
            else if (busy) busyCnt++;
        end
        checkOutput({name, "_doneSeen"}, doneSeen, 1);
        checkOutput({name, "_busyCycles"}, busyCnt, expBusy);
        checkOutput({name, "_busyAtDone"}, int'(busy), 0);
        checkOutput({name, "_stallMirror"}, stallBad, 0);
        @(negedge clock);
        checkOutput({name, "_donePulseEnd"}, int'(done), 0);
        if (m == MODE_FILL) refFill(d, l, f);
        else refCopy(s, d, l);
        checkMemory(name);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_val = '0; cpu_addr = 8'h77; cpu_we = 1'b1; cpu_data = 16'hDEAD;
        for (int a = 0; a < 256; a++) refMem[a] = 16'h0000;

        // Reset state with a CPU write request held: no write may escape.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_stall", int'(stall), 0);
        checkOutput("reset_memWe", int'(mem_we), 0);
        cpu_we = 1'b0;
        reset  = 1'b0;

        for (int a = 0; a < 256; a++) cpuWrite(8'(a), 16'h0000);

        // CPU passthrough while idle.
        @(negedge clock);
        cpu_addr = 8'h55; cpu_data = 16'h7777; cpu_we = 1'b1;
        #1;
        checkOutput("idle_passAddr", int'(mem_addr), 'h55);
        checkOutput("idle_passWe", int'(mem_we), 1);
        checkOutput("idle_passData", int'(mem_data), 'h7777);
        @(posedge clock);
        #1 cpu_we = 1'b0;
        refMem[8'h55] = 16'h7777;
        checkOutput("idle_cpuQ", int'(cpu_q), 'h7777);

        for (int k = 0; k < 4; k++) cpuWrite(8'h10 + 8'(k), 16'hA001 + 16'(k));
        cpuWrite(8'h40, 16'h0001);
        cpuWrite(8'h41, 16'h0002);

        vecs[0] = '{"copy4",     MODE_COPY, 8'h10, 8'h80, 8'd4, 16'h0000, 8};
        vecs[1] = '{"fillWrap",  MODE_FILL, 8'h00, 8'hFE, 8'd3, 16'h5A5A, 3};
        vecs[2] = '{"zeroLen",   MODE_COPY, 8'h10, 8'hC0, 8'd0, 16'h0000, 0};
        vecs[3] = '{"overlap",   MODE_COPY, 8'h40, 8'h41, 8'd2, 16'h0000, 4};
        vecs[4] = '{"fill1",     MODE_FILL, 8'h00, 8'h50, 8'd1, 16'hBEEF, 1};
        vecs[5] = '{"copyWrapS", MODE_COPY, 8'hFE, 8'h30, 8'd3, 16'h0000, 6};

        for (int v = 0; v < 6; v++)
            applyStimulus(vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].l, vecs[v].f,
                          vecs[v].expBusy, vecs[v].name);

        checkOutput("copy4_mem80", int'(mem[8'h80]), 'hA001);
        checkOutput("copy4_mem83", int'(mem[8'h83]), 'hA004);
        checkOutput("fillWrap_memFF", int'(mem[8'hFF]), 'h5A5A);
        checkOutput("fillWrap_mem00", int'(mem[8'h00]), 'h5A5A);
        checkOutput("overlap_mem41", int'(mem[8'h41]), 'h0001);
        checkOutput("overlap_mem42", int'(mem[8'h42]), 'h0001);
        checkOutput("copyWrapS_mem32", int'(mem[8'h32]), 'h5A5A);

        // Arbitration: a CPU write held through a busy copy lands only after.
        begin
            int bad = 0;
            int cyc = 0;
            int sawDone = 0;
            cpuWrite(8'h20, 16'hCAFE);
            @(negedge clock);
            mode = MODE_COPY; src = 8'h10; dst = 8'hA0; len = 8'd3; start = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            cpu_addr = 8'h20; cpu_data = 16'h1234; cpu_we = 1'b1;
            while (sawDone == 0 && cyc < 100) begin
                @(negedge clock);
                cyc++;
                if (mem[8'h20] !== 16'hCAFE) bad++;
                if (done) sawDone = 1;
            end
            checkOutput("arb_doneSeen", sawDone, 1);
            checkOutput("arb_heldWhileBusy", bad, 0);
            @(negedge clock);
            checkOutput("arb_writtenAfter", int'(mem[8'h20]), 'h1234);
            cpu_we = 1'b0;
            refCopy(8'h10, 8'hA0, 8'd3);
            refMem[8'h20] = 16'h1234;
            checkMemory("arb");
        end

        // Reset after the second write of a four-word copy.
        begin
            int doneCnt = 0;
            @(negedge clock);
            mode = MODE_COPY; src = 8'h10; dst = 8'h90; len = 8'd4; start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
            repeat (4) begin
                @(negedge clock);
                if (done) doneCnt++;
            end
            @(posedge clock);
            @(negedge clock);
            if (done) doneCnt++;
            reset = 1'b1; cpu_addr = 8'h33; cpu_data = 16'h4444; cpu_we = 1'b1;
            #1 checkOutput("midReset_memWeBlocked", int'(mem_we), 0);
            @(posedge clock);
            @(negedge clock);
            reset = 1'b0; cpu_we = 1'b0;
            #1;
            if (done) doneCnt++;
            checkOutput("midReset_busy", int'(busy), 0);
            checkOutput("midReset_noDone", doneCnt, 0);
            checkOutput("midReset_passAddr", int'(mem_addr), 'h33);
            checkOutput("midReset_passData", int'(mem_data), 'h4444);
            refCopy(8'h10, 8'h90, 8'd2);
            checkMemory("midReset");
            checkOutput("midReset_mem92", int'(mem[8'h92]), 0);
        end

        // Start held high through DONE must not retrigger.
        @(negedge clock);
        mode = MODE_FILL; dst = 8'h60; len = 8'd2; fill_val = 16'h1111; start = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("heldStart_done", int'(done), 1);
        @(negedge clock);
        checkOutput("heldStart_idleBusy", int'(busy), 0);
        checkOutput("heldStart_idleDone", int'(done), 0);
        start = 1'b0;
        @(negedge clock);
        checkOutput("heldStart_stayIdle", int'(busy), 0);
        refFill(8'h60, 8'd2, 16'h1111);
        checkMemory("heldStart");

        // Randomized requests against the reference memory image.
        for (int r = 0; r < 20; r++) begin
            logic        rm;
            logic [7:0]  rs;
            logic [7:0]  rd;
            logic [7:0]  rl;
            logic [15:0] rf;
            int          eb;
            rm = 1'($urandom);
            rs = 8'($urandom);
            rd = (r % 4 == 0) ? rs + 8'($urandom_range(1, 3)) : 8'($urandom);
            rl = 8'($urandom_range(0, 12));
            rf = 16'($urandom);
            eb = (rl == 0) ? 0 : ((rm == MODE_FILL) ? int'(rl) : 2 * int'(rl));
            applyStimulus(rm, rs, rd, rl, rf, eb, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_dma.md
DMEM_DMA -- requirements
Module: dmem_dma

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be the data-memory word-address width.
REQ-002 Parameter DATA_W, default 16, SHALL be the data-memory word width.
REQ-003 clock  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start  in  1  SHALL be the request strobe, sampled only in IDLE.
REQ-006 mode  in  1  SHALL select the operation: 0 = copy, 1 = fill.
REQ-007 src, dst  in  ADDR_W  SHALL be the copy source and the copy/fill destination base addresses.
REQ-008 len  in  ADDR_W  SHALL be the word count; 0 is a legal no-op.
REQ-009 fill_val  in  DATA_W  SHALL be the fill pattern.
REQ-010 busy  out  1  SHALL be high in READ, WRITE and FILL.
REQ-011 done  out  1  SHALL be a one-cycle completion pulse.
REQ-012 stall  out  1  SHALL equal busy and tells the CPU memory stage to hold.
REQ-013 cpu_addr  in  ADDR_W, cpu_we  in  1, cpu_data  in  DATA_W, cpu_q  out  DATA_W  SHALL form the CPU-side memory port.
REQ-014 mem_addr  out  ADDR_W, mem_we  out  1, mem_data  out  DATA_W, mem_q  in  DATA_W  SHALL drive the data memory: asynchronous read, write on the clock edge when mem_we is high.

Function
REQ-015 States SHALL be IDLE, READ, WRITE, FILL and DONE.
REQ-016 IDLE + start + len=0 SHALL go to DONE.
REQ-017 IDLE + start + len>0 SHALL latch src, dst, len, fill_val and mode, clear the index i, then go to READ (copy) or FILL (fill).
REQ-018 READ SHALL drive mem_addr=src+i and mem_we=0, capture mem_q into a word register, then go to WRITE.
REQ-019 WRITE SHALL drive mem_addr=dst+i, mem_we=1 and mem_data=the word register, then increment i; it goes to DONE if i+1=len, else to READ.
REQ-020 FILL SHALL drive mem_addr=dst+i, mem_we=1 and mem_data=fill_val, then increment i; it stays in FILL until i+1=len, then goes to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-022 Latency SHALL be: copy = 2*len busy cycles + 1 DONE cycle; fill = len busy cycles + 1 DONE cycle.
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_W, so src+i and dst+i wrap from 255 to 0.
REQ-024 Copy SHALL run strictly ascending, one word at a time; an overlapping forward copy (dst in src+1..src+len-1) SHALL replicate earlier words, with no special handling.
REQ-025 start SHALL be ignored in any state other than IDLE; a start already high in DONE SHALL not trigger a new request until IDLE.
REQ-026 In IDLE and DONE, mem_addr, mem_we and mem_data SHALL pass through combinationally from cpu_addr, cpu_we and cpu_data.
REQ-027 When busy, cpu_we SHALL be ignored and the memory port driven only by the DMA.
REQ-028 cpu_q SHALL always equal mem_q.
REQ-029 Input changes on src, dst, len, fill_val or mode after acceptance SHALL not affect the operation in progress.

Reset
REQ-030 Reset SHALL force IDLE, i=0, the word register=0, busy=0, done=0 and stall=0.
REQ-031 While reset is high, mem_we SHALL be 0 regardless of cpu_we.
REQ-032 Reset mid-operation SHALL abort at that edge with no done pulse; words already written SHALL remain in memory.

Structure
REQ-033 A shared package/header SHALL hold ADDR_W, DATA_W, the state encodings and the mode codes (MODE_COPY=0, MODE_FILL=1).
REQ-034 The block SHALL be one module with no sub-modules; the port mux SHALL be combinational logic in dmem_dma.
REQ-035 The bench SHALL pair the block with the existing simulation data-memory model.

Verification
REQ-036 Copy: preload mem[0x10..0x13] = 0xA001..0xA004; start with mode=0, src=0x10, dst=0x80, len=4 -> busy for 8 cycles, done on cycle 9, mem[0x80..0x83] = 0xA001..0xA004, stall mirrors busy.
REQ-037 Fill with wrap: mode=1, dst=0xFE, len=3, fill_val=0x5A5A -> mem[0xFE], mem[0xFF] and mem[0x00] = 0x5A5A; busy for 3 cycles, then done.
REQ-038 Zero length: start with len=0 -> done the next cycle, busy never asserted, no memory write.
REQ-039 Arbitration: cpu_we=1, cpu_addr=0x20, cpu_data=0x1234 held throughout a busy copy -> mem[0x20] unchanged while busy; written with 0x1234 once IDLE returns.
REQ-040 Reset mid-copy: len=4, assert reset after the second WRITE -> two destination words written, two untouched, no done pulse; next cycle busy=0 and the port is passed through.
REQ-041 Overlap: mem[0x40]=0x0001, mem[0x41]=0x0002; copy src=0x40, dst=0x41, len=2 -> mem[0x41]=0x0001 and mem[0x42]=0x0001.
